seq_onehot_decoder: RTL

Parametrised, registered N-to-2^N one-hot decoder. It replaces the purely combinational 3-to-8 decoder used for select generation. It adds an enable, a load strobe, an output-polarity option and an auto-scan mode. In scan mode it steps the select through all 2^N lines at a programmable rate, for display-digit strobing and bus-slave polling. It sits between control logic and the select/strobe lines it drives.

---
 rtl/seq_onehot_decoder_if.sv | 25 ++
 rtl/seq_onehot_decoder.sv | 101 ++++++++++
 2 files changed

// File: rtl/seq_onehot_decoder_if.sv
// rtl/seq_onehot_decoder_if.sv - control and decode-output bundle for seq_onehot_decoder
interface seq_onehot_decoder_if #(
  parameter int N = 3
);
  localparam int W = 1 << N;

  logic         en;
  logic         mode;
  logic         load;
  logic [N-1:0] sel_in;
  logic [W-1:0] dout;
  logic [N-1:0] sel_out;
  logic         valid;
  logic         wrap;

  modport master (
    output en, mode, load, sel_in,
    input  dout, sel_out, valid, wrap
  );

  modport slave (
    input  en, mode, load, sel_in,
    output dout, sel_out, valid, wrap
  );
endinterface

// File: rtl/seq_onehot_decoder.sv
// rtl/seq_onehot_decoder.sv - registered N-to-2^N one-hot decoder with load, scan and polarity
module seq_onehot_decoder #(
  parameter int N          = 3,
  parameter int PERIOD     = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_onehot_decoder_if.slave  bus
);
  localparam int W  = 1 << N;
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(PERIOD - 1);
  localparam logic [W-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [W-1:0]  ONE      = W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIRECT = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [N-1:0]  sel, sel_nxt;
  logic          valid_q, valid_nxt;
  logic          wrap_q, wrap_nxt;
  logic [W-1:0]  dout_q, dout_nxt;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    sel_nxt   = sel;
    valid_nxt = valid_q;
    wrap_nxt  = 1'b0;
    if (!bus.en) begin
      state_nxt = S_IDLE;
      presc_nxt = '0;
      sel_nxt   = '0;
      valid_nxt = 1'b0;
    end else if (bus.load) begin
      state_nxt = bus.mode ? S_SCAN : S_DIRECT;
      presc_nxt = '0;
      sel_nxt   = bus.sel_in;
      valid_nxt = 1'b1;
    end else begin
      case (state)
        S_DIRECT: begin
          if (bus.mode) begin
            state_nxt = S_SCAN;
            presc_nxt = '0;
          end
        end
        S_SCAN: begin
          // Leaving scan freezes the select where it stands; no step on that edge.
          if (!bus.mode) begin
            state_nxt = S_DIRECT;
          end else if (presc == P_LAST) begin
            presc_nxt = '0;
            sel_nxt   = sel + N'(1);
            wrap_nxt  = &sel;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // The decode is taken from the next select so dout lines up with sel_out.
  always_comb begin
    dout_nxt = INACTIVE;
    if (valid_nxt) begin
      dout_nxt = (ONE << sel_nxt) ^ INACTIVE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      presc   <= '0;
      sel     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      dout_q  <= INACTIVE;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      sel     <= sel_nxt;
      valid_q <= valid_nxt;
      wrap_q  <= wrap_nxt;
      dout_q  <= dout_nxt;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.sel_out = sel;
  assign bus.valid   = valid_q;
  assign bus.wrap    = wrap_q;
endmodule
